// File: rtl/odometry_pkg.sv
// odometry_pkg: record layout, widths and saturation constant shared by the odometry sampler
package odometry_pkg;
  localparam int REC_W    = 128;
  localparam int FLIT_LSB = 0;
  localparam int FLIT_W   = 32;
  localparam int PKT_LSB  = 32;
  localparam int PKT_W    = 32;
  localparam int VAL_LSB  = 64;
  localparam int VAL_W    = 32;
  localparam int SEQ_LSB  = 96;
  localparam int SEQ_W    = 16;
  localparam int DROP_LSB = 112;
  localparam int DROP_W   = 16;
  localparam logic [DROP_W-1:0] DROP_SAT = '1;

  function automatic logic [DROP_W-1:0] drop_inc(input logic [DROP_W-1:0] x);
    return (x == DROP_SAT) ? x : x + 1'b1;
  endfunction
endpackage

// File: rtl/odometry_delta.sv
// odometry_delta: wrap-safe counter difference saturated to SAT_W bits
module odometry_delta
  import odometry_pkg::*;
#(
  parameter int CNT_W = 64,
  parameter int SAT_W = 32
) (
  input  logic [CNT_W-1:0] cur,
  input  logic [CNT_W-1:0] snap,
  output logic [SAT_W-1:0] delta
);
  logic [CNT_W-1:0] diff;
  assign diff = cur - snap;
  generate
    if (CNT_W > SAT_W) begin : g_sat
      assign delta = |diff[CNT_W-1:SAT_W] ? '1 : diff[SAT_W-1:0];
    end else begin : g_pass
      assign delta = SAT_W'(diff);
    end
  endgenerate
endmodule

// File: rtl/odometry_sampler.sv
// odometry_sampler: periodic flit/packet delta records over AXI-Stream with drop merging and peak tracking
module odometry_sampler
  import odometry_pkg::*;
#(
  parameter int CNT_W = 64,
  parameter int SAT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CNT_W-1:0] flit_count,
  input  logic [CNT_W-1:0] packet_count,
  input  logic [31:0]      value,
  input  logic [31:0]      interval,
  input  logic             clear_peak,
  output logic [REC_W-1:0] sample_tdata,
  output logic             sample_tvalid,
  input  logic             sample_tready,
  output logic [SAT_W-1:0] peak_flit_delta
);
  logic [31:0]       timer;
  logic [CNT_W-1:0]  flit_snap;
  logic [CNT_W-1:0]  pkt_snap;
  logic [SEQ_W-1:0]  seq;
  logic [DROP_W-1:0] dropped;
  logic [SAT_W-1:0]  flit_delta;
  logic [SAT_W-1:0]  pkt_delta;
  logic [REC_W-1:0]  rec_next;
  logic [SAT_W-1:0]  peak_next;
  logic              tick;
  logic              load;
  logic              drop;

  odometry_delta #(.CNT_W(CNT_W), .SAT_W(SAT_W)) u_flit (
    .cur(flit_count), .snap(flit_snap), .delta(flit_delta)
  );

  odometry_delta #(.CNT_W(CNT_W), .SAT_W(SAT_W)) u_pkt (
    .cur(packet_count), .snap(pkt_snap), .delta(pkt_delta)
  );

  // tick is compared with >= so shrinking interval mid-period fires at once
  assign tick = (interval != '0) && (({1'b0, timer} + 33'd1) >= {1'b0, interval});
  assign load = tick && (!sample_tvalid || sample_tready);
  assign drop = tick && sample_tvalid && !sample_tready;

  // assemble the outgoing record and the next peak value
  always_comb begin
    rec_next = '0;
    rec_next[FLIT_LSB +: FLIT_W] = FLIT_W'(flit_delta);
    rec_next[PKT_LSB +: PKT_W]   = PKT_W'(pkt_delta);
    rec_next[VAL_LSB +: VAL_W]   = VAL_W'(value);
    rec_next[SEQ_LSB +: SEQ_W]   = seq;
    rec_next[DROP_LSB +: DROP_W] = dropped;
    peak_next = peak_flit_delta;
    if (load)
      peak_next = (clear_peak || flit_delta > peak_flit_delta) ? flit_delta : peak_flit_delta;
    else if (clear_peak)
      peak_next = '0;
  end

  // sample period timer, parked at zero while sampling is disabled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      timer <= '0;
    else
      timer <= (interval == '0 || tick) ? '0 : timer + 1'b1;
  end

  // snapshots track inputs while disabled and advance only on emitted records
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flit_snap <= '0;
      pkt_snap  <= '0;
    end else if (interval == '0 || load) begin
      flit_snap <= flit_count;
      pkt_snap  <= packet_count;
    end
  end

  // output record register with handshake, sequence and drop accounting
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sample_tvalid <= 1'b0;
      sample_tdata  <= '0;
      seq           <= '0;
      dropped       <= '0;
    end else begin
      sample_tvalid <= load || (sample_tvalid && !sample_tready);
      if (load) begin
        sample_tdata <= rec_next;
        seq          <= seq + 1'b1;
      end
      dropped <= load ? '0 : drop ? drop_inc(dropped) : dropped;
    end
  end

  // peak of emitted flit deltas
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      peak_flit_delta <= '0;
    else
      peak_flit_delta <= peak_next;
  end
endmodule

// File: tb/tb_odometry_sampler.sv
// tb_odometry_sampler: directed scenarios with a record scoreboard popped on each handshake
module tb_odometry_sampler;
  logic         clk;
  logic         rstn;
  logic [63:0]  flit_count;
  logic [63:0]  packet_count;
  logic [31:0]  value;
  logic [31:0]  interval;
  logic         clear_peak;
  logic [127:0] sample_tdata;
  logic         sample_tvalid;
  logic         sample_tready;
  logic [31:0]  peak_flit_delta;

  logic [127:0] exp_q[$];
  logic [127:0] held;
  logic [63:0]  flit_inc;
  int           pkt_div;
  int           cyc;
  int           n_tests;
  int           n_fail;
  int           vcount;
  bit           have;

  odometry_sampler #(.CNT_W(64), .SAT_W(32)) dut (
    .clk(clk), .rstn(rstn), .flit_count(flit_count), .packet_count(packet_count),
    .value(value), .interval(interval), .clear_peak(clear_peak),
    .sample_tdata(sample_tdata), .sample_tvalid(sample_tvalid),
    .sample_tready(sample_tready), .peak_flit_delta(peak_flit_delta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rec(input logic [31:0] f, input logic [31:0] p,
                                       input logic [31:0] v, input logic [15:0] s,
                                       input logic [15:0] d);
    return {d, s, v, p, f};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [127:0] e;
    if (sample_tvalid && sample_tready) begin
      chk("rec_pending", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rec", sample_tdata, e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    flit_count += flit_inc;
    if (pkt_div != 0 && cyc % pkt_div == 0) packet_count += 64'd1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    rstn = 1'b0; flit_count = '0; packet_count = '0; value = '0; interval = '0;
    clear_peak = 1'b0; sample_tready = 1'b1; flit_inc = '0; pkt_div = 0;
    @(posedge clk);
    #1;
    chk("rst_tvalid", 128'(sample_tvalid), 128'd0);
    chk("rst_tdata", sample_tdata, 128'd0);
    chk("rst_peak", 128'(peak_flit_delta), 128'd0);
    rstn = 1'b1;

    // steady sampling, 100-cycle interval
    flit_inc = 64'd1; pkt_div = 4; value = 32'd1000000000;
    steps(3);
    interval = 32'd100;
    for (int s = 0; s < 3; s++) exp_q.push_back(rec(32'd100, 32'd25, 32'd1000000000, 16'(s), 16'd0));
    steps(302);
    interval = '0;
    chk("s1_q_empty", 128'(exp_q.size()), 128'd0);
    chk("s1_peak", 128'(peak_flit_delta), 128'd100);

    // backpressure merges windows
    do_reset();
    sample_tready = 1'b0; pkt_div = 1; value = 32'd250000000;
    steps(3);
    interval = 32'd10;
    exp_q.push_back(rec(32'd10, 32'd10, 32'd250000000, 16'd0, 16'd0));
    exp_q.push_back(rec(32'd40, 32'd40, 32'd250000000, 16'd1, 16'd3));
    have = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (sample_tvalid) begin
        if (!have) begin
          held = sample_tdata;
          have = 1'b1;
        end else chk("s2_stable", sample_tdata, held);
      end
    end
    chk("s2_held_seen", 128'(have), 128'd1);
    sample_tready = 1'b1;
    steps(5);
    chk("s2_rec2_valid", 128'(sample_tvalid), 128'd1);
    step();
    chk("s2_tvalid_drop", 128'(sample_tvalid), 128'd0);
    steps(2);
    interval = '0;
    chk("s2_q_empty", 128'(exp_q.size()), 128'd0);
    chk("s2_peak", 128'(peak_flit_delta), 128'd40);

    // 64-bit counter wrap
    do_reset();
    pkt_div = 0; value = 32'h12345678;
    flit_count = 64'hFFFF_FFFF_FFFF_FFF0; flit_inc = 64'd1;
    step();
    interval = 32'd32;
    exp_q.push_back(rec(32'h20, 32'd0, 32'h12345678, 16'd0, 16'd0));
    steps(33);
    interval = '0;
    chk("s3_q_empty", 128'(exp_q.size()), 128'd0);
    chk("s3_peak", 128'(peak_flit_delta), 128'h20);

    // saturation and peak clear
    flit_inc = '0; flit_count = 64'h100; value = 32'hDEADBEEF;
    steps(2);
    interval = 32'd5;
    flit_count = 64'h100 + 64'h1_0000_0005;
    exp_q.push_back(rec(32'hFFFF_FFFF, 32'd0, 32'hDEADBEEF, 16'd1, 16'd0));
    steps(6);
    interval = '0;
    chk("s4_q_empty", 128'(exp_q.size()), 128'd0);
    chk("s4_peak_sat", 128'(peak_flit_delta), 128'hFFFF_FFFF);
    clear_peak = 1'b1;
    step();
    clear_peak = 1'b0;
    chk("s4_peak_clr", 128'(peak_flit_delta), 128'd0);

    // disabled sampling then enable
    flit_inc = 64'd1; value = 32'd777; vcount = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (sample_tvalid) vcount++;
    end
    chk("s5_no_tvalid", 128'(vcount), 128'd0);
    interval = 32'd50;
    exp_q.push_back(rec(32'd50, 32'd0, 32'd777, 16'd2, 16'd0));
    steps(49);
    chk("s5_not_yet", 128'(sample_tvalid), 128'd0);
    step();
    chk("s5_first_rec", 128'(sample_tvalid), 128'd1);
    step();
    interval = '0;
    chk("s5_q_empty", 128'(exp_q.size()), 128'd0);
    chk("s5_peak", 128'(peak_flit_delta), 128'd50);

    // asynchronous reset while a record is pending
    sample_tready = 1'b0; value = 32'd42;
    interval = 32'd10;
    for (int i = 0; i < 20 && !sample_tvalid; i++) step();
    chk("s6_valid", 128'(sample_tvalid), 128'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("s6_async_tvalid", 128'(sample_tvalid), 128'd0);
    chk("s6_async_tdata", sample_tdata, 128'd0);
    interval = '0; sample_tready = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    steps(2);
    interval = 32'd10;
    exp_q.push_back(rec(32'd10, 32'd0, 32'd42, 16'd0, 16'd0));
    steps(11);
    interval = '0;
    step();
    chk("s6_q_empty", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/odometry_sampler.md
ODOMETRY_SAMPLER -- requirements
Module: odometry_sampler

Interface
REQ-001 Parameter CNT_W, default 64, SHALL set the width of the monitored counter inputs.
REQ-002 Parameter SAT_W, default 32, SHALL set the width of the delta fields in the record.
REQ-003 clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 rstn  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 flit_count  in  CNT_W  SHALL be the accepted-flit counter from the upstream monitor.
REQ-006 packet_count  in  CNT_W  SHALL be the accepted-tlast counter from the upstream monitor.
REQ-007 value  in  32  SHALL be the upstream utilisation EWMA, with 1e9 = 100%.
REQ-008 interval  in  32  SHALL be the sample period in clk cycles; 0 disables sampling.
REQ-009 clear_peak  in  1  SHALL be a single-cycle pulse that clears peak_flit_delta.
REQ-010 sample_tdata  out  128  SHALL carry the record: [31:0] flit_delta, [63:32] packet_delta, [95:64] value snapshot, [111:96] seq, [127:112] dropped.
REQ-011 sample_tvalid / sample_tready  out/in  1  SHALL form the AXI-Stream handshake for the record.
REQ-012 peak_flit_delta  out  SAT_W  SHALL hold the largest flit_delta emitted since reset or the last clear.

Function
REQ-013 A timer SHALL count 0..interval-1 and assert an internal tick in the cycle where timer+1 >= interval; the timer then returns to 0.
- A reduced interval therefore takes effect immediately.
REQ-014 While interval==0: no ticks; timer held at 0; both snapshot registers reload with the current inputs every cycle.
REQ-015 On tick: delta = input - snapshot, using CNT_W modular subtraction (counter wrap-around yields the correct delta).
REQ-016 Each delta SHALL saturate to SAT_W bits: any nonzero upper bit gives all-ones.
REQ-017 On tick, if sample_tvalid==0 or sample_tready==1 in that cycle, the record SHALL load:
- sample_tvalid=1 on the next cycle (latency 1);
- snapshots updated to the current inputs;
- seq incremented after use;
- dropped counter cleared after use.
REQ-018 On tick with sample_tvalid==1 and sample_tready==0:
- the record is dropped and the snapshots are NOT updated, so the next emitted deltas span all merged windows;
- dropped increments, saturating at 0xFFFF.
REQ-019 While sample_tvalid==1 and sample_tready==0, sample_tdata SHALL hold stable.
REQ-020 sample_tvalid SHALL deassert the cycle after a handshake with no simultaneous tick; a simultaneous tick reloads back-to-back.
REQ-021 seq SHALL be 16-bit, wrap 0xFFFF->0, and count emitted records only.
REQ-022 peak_flit_delta SHALL update to max(peak, flit_delta) on each record load.
- When clear_peak coincides with a load, the result is the new flit_delta.
REQ-023 The value field SHALL be the value input sampled at the tick cycle, unsaturated.

Reset
REQ-024 rstn low SHALL asynchronously force the following to 0: sample_tvalid, sample_tdata, peak_flit_delta, timer, snapshots, seq, dropped.
REQ-025 Reset mid-record SHALL drop tvalid without a clock edge.
REQ-026 After rstn rises, the first tick SHALL occur interval cycles later.

Structure
REQ-027 Shared package odometry_pkg SHALL hold the record field offsets and widths, the record width (128), and the saturation constant.
REQ-028 A sub-module odometry_delta SHALL implement the modular subtract-and-saturate; it is instantiated twice (flit, packet).

Verification
REQ-029 The bench SHALL cover each of these scenarios:
- interval=100, flit +1/cycle, packet +1 every 4 cycles, tready=1 -> records flit_delta=100, packet_delta=25, seq=0,1,2, dropped=0.
- interval=10, flit +1/cycle, tready=0 across ticks 2-4, raised before tick 5 -> record 1 held stable; next record flit_delta=40, dropped=3, seq=1.
- Snapshot 0xFFFF_FFFF_FFFF_FFF0, flit_count wraps to 0x10 at tick -> flit_delta=0x20.
- Delta 0x1_0000_0005 -> flit_delta=0xFFFF_FFFF and peak_flit_delta=0xFFFF_FFFF; clear_peak pulse -> peak=0.
- interval=0 for 200 cycles, then 50 -> no tvalid while 0; first record 50 cycles after enable, holding only post-enable counts.
- rstn low while tvalid=1 -> tvalid=0 asynchronously; after release, seq restarts at 0.
